mem_access: RTL
===============

Name: mem_access

Overview:
- Memory-access stage of the flat RISC-V pipeline. Consumes the execute stage's registered results (IR, ALU result, compare flag, PC, store data).
- Performs loads and stores against data memory over a req/ack handshake and resolves branch and jump redirects.
- Presents registered writeback data to the writeback stage.
- Stalls upstream while a memory transaction is outstanding.

Parameters:
- ADDR_W, 32, width of dmem_addr; the word address is ALU_in[ADDR_W-1:2] concatenated with 2'b00.
- LINK_OFFSET, 4, value added to PC_in to form the JAL/JALR link result.

Ports:
- clk  input  1  pipeline clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- valid_in  input  1  execute-stage outputs hold a live instruction
- IR_in  input  32  instruction from execute stage
- ALU_in  input  32  effective address, branch/jump target, or arithmetic result
- COMP_in  input  1  branch condition from execute stage
- PC_in  input  32  instruction PC
- B_in  input  32  store data (rs2)
- stall  output  1  combinational; upstream must hold all *_in stable while high
- dmem_req  output  1  memory request, registered
- dmem_we  output  1  1 = store, 0 = load
- dmem_addr  output  ADDR_W  word-aligned address
- dmem_wdata  output  32  lane-replicated store data
- dmem_be  output  4  byte enables
- dmem_ack  input  1  one-cycle completion pulse
- dmem_rdata  input  32  read word, valid when dmem_ack is high
- valid_out  output  1  outputs below carry a retired instruction
- IR_out  output  32  registered instruction
- WB_out  output  32  writeback value
- rd_we  output  1  register write enable; low when rd = 0
- PC_out  output  32  registered PC
- redirect  output  1  taken branch or jump
- redirect_pc  output  32  redirect target
- misalign  output  1  misaligned load or store detected

Behaviour:
- Reset (async, rst_n = 0):
  - FSM goes to IDLE.
  - All registered outputs are 0: dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, valid_out, IR_out, WB_out, rd_we, PC_out, redirect, redirect_pc, misalign.
  - Reset mid-transaction drops dmem_req immediately. The outstanding access is abandoned and no writeback occurs.
- Opcode classes (IR_in[6:0]):
  - LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111.
  - Everything else is ALU.
  - f3 = IR_in[14:12].
- Alignment:
  - Halfword access requires ALU_in[0] = 0.
  - Word access requires ALU_in[1:0] = 0.
  - Byte access is always aligned.
- FSM states: IDLE and WAIT.
  - IDLE, valid_in = 1, aligned LOAD or STORE:
    - stall = 1.
    - At the clock edge: go to WAIT; dmem_req <= 1; latch we, addr, wdata, be and the instruction context.
    - valid_out <= 0.
  - IDLE, any other case:
    - stall = 0.
    - At the clock edge: valid_out <= valid_in and all outputs are registered, giving 1-cycle latency.
    - A misaligned LOAD or STORE issues no request: misalign <= 1, WB_out <= 0, rd_we <= 0, valid_out <= 1.
  - WAIT:
    - stall = !dmem_ack.
    - dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_be stay stable until the ack.
    - On dmem_ack: dmem_req <= 0; result registered; valid_out <= 1; go to IDLE. Upstream advances in that same cycle.
    - dmem_ack may arrive in the first WAIT cycle.
  - dmem_ack received while in IDLE is ignored.
  - Back-to-back memory ops: after the ack cycle the next op enters IDLE and is accepted the following cycle. dmem_req is therefore low for at least one cycle between requests.
- Store byte enables and data:
  - SB: be = 0001 << addr[1:0]; wdata = {4{B[7:0]}}.
  - SH: be = 0011 << {addr[1],1'b0}; wdata = {2{B[15:0]}}.
  - SW: be = 1111; wdata = B.
- Load extraction (lane selected by the latched addr[1:0]):
  - LB and LH sign-extend.
  - LBU and LHU zero-extend.
  - LW passes the word through.
  - f3 values 011, 110 and 111 are treated as LW.
- WB_out and rd_we:
  - LOAD: extracted data.
  - JAL and JALR: PC_in + LINK_OFFSET, modulo 2^32.
  - ALU class: ALU_in.
  - STORE and BRANCH: rd_we = 0.
  - For all other classes: rd_we = valid & (IR[11:7] != 0).
- Redirect:
  - BRANCH with COMP_in = 1: redirect = 1, redirect_pc = ALU_in.
  - JAL: redirect = 1, redirect_pc = ALU_in.
  - JALR: redirect = 1, redirect_pc = ALU_in & ~1.
  - redirect is high for exactly the one cycle valid_out is high. It is never asserted when valid_in = 0.
- misalign is a one-cycle flag coincident with valid_out.

Test Plan:
- ALU op: IR = ADD x5, ALU_in = 0x0000_0007, valid_in = 1 -> next cycle: valid_out = 1, WB_out = 7, rd_we = 1, stall = 0, dmem_req = 0.
- LB with ALU_in = 0x103, ack 3 cycles after dmem_req rises, dmem_rdata = 0x80FF_1234:
  - stall stays high until the ack cycle.
  - dmem_addr = 0x100; WB_out = 0xFFFF_FF80.
  - LBU of the same access -> WB_out = 0x80.
- SH with ALU_in = 0x202, B_in = 0x1234_ABCD -> dmem_we = 1, dmem_be = 1100, dmem_wdata = 0xABCD_ABCD, dmem_addr = 0x200; on ack: rd_we = 0.
- Misaligned LW with ALU_in = 0x102 -> no dmem_req; next cycle misalign = 1, valid_out = 1, rd_we = 0.
- Redirects:
  - BEQ with COMP_in = 1, ALU_in = 0x40 -> redirect = 1, redirect_pc = 0x40.
  - COMP_in = 0 -> redirect = 0.
  - JALR with ALU_in = 0x81, PC_in = 0x10 -> redirect_pc = 0x80, WB_out = 0x14.
- Assert rst_n = 0 while in WAIT -> dmem_req drops immediately; all outputs 0. A late dmem_ack after reset release causes no valid_out.

Source files
------------

// File: rtl/mem_access.sv
// Memory-access stage: issues loads/stores over a req/ack handshake, resolves branch/jump redirects,
// and registers writeback results. Latency 1 cycle for non-memory ops, ack+1 for memory ops.
module mem_access #(
  parameter int ADDR_W      = 32,
  parameter int LINK_OFFSET = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [31:0]       IR_in,
  input  logic [31:0]       ALU_in,
  input  logic              COMP_in,
  input  logic [31:0]       PC_in,
  input  logic [31:0]       B_in,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              valid_out,
  output logic [31:0]       IR_out,
  output logic [31:0]       WB_out,
  output logic              rd_we,
  output logic [31:0]       PC_out,
  output logic              redirect,
  output logic [31:0]       redirect_pc,
  output logic              misalign
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t state;

  logic [31:0] ir_q;
  logic [31:0] pc_q;
  logic [1:0]  lane_q;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic        is_load, is_store, is_branch, is_jal, is_jalr, is_mem;
  logic        aligned, accept;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [31:0] link;
  logic [31:0] shifted;
  logic [31:0] load_data;

  assign opc       = IR_in[6:0];
  assign f3        = IR_in[14:12];
  assign is_load   = (opc == OP_LOAD);
  assign is_store  = (opc == OP_STORE);
  assign is_branch = (opc == OP_BRANCH);
  assign is_jal    = (opc == OP_JAL);
  assign is_jalr   = (opc == OP_JALR);
  assign is_mem    = is_load | is_store;
  assign link      = PC_in + 32'(LINK_OFFSET);

  // f3[1:0] encodes access size for both loads and stores; 10/11 are word.
  always_comb begin
    aligned = 1'b1;
    be_n    = 4'b1111;
    wdata_n = B_in;
    case (f3[1:0])
      2'b00: begin
        be_n    = 4'b0001 << ALU_in[1:0];
        wdata_n = {4{B_in[7:0]}};
      end
      2'b01: begin
        aligned = ~ALU_in[0];
        be_n    = 4'b0011 << {ALU_in[1], 1'b0};
        wdata_n = {2{B_in[15:0]}};
      end
      default: aligned = (ALU_in[1:0] == 2'b00);
    endcase
  end

  assign accept = valid_in & is_mem & aligned;
  assign stall  = (state == S_IDLE) ? accept : ~dmem_ack;

  assign shifted = dmem_rdata >> {lane_q, 3'b000};
  always_comb begin
    case (ir_q[14:12])
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {24'd0, shifted[7:0]};
      3'b101:  load_data = {16'd0, shifted[15:0]};
      default: load_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      dmem_be     <= '0;
      valid_out   <= 1'b0;
      IR_out      <= '0;
      WB_out      <= '0;
      rd_we       <= 1'b0;
      PC_out      <= '0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
      misalign    <= 1'b0;
      ir_q        <= '0;
      pc_q        <= '0;
      lane_q      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state      <= S_WAIT;
            dmem_req   <= 1'b1;
            dmem_we    <= is_store;
            dmem_addr  <= {ALU_in[ADDR_W-1:2], 2'b00};
            dmem_wdata <= wdata_n;
            dmem_be    <= is_store ? be_n : 4'b1111;
            ir_q       <= IR_in;
            pc_q       <= PC_in;
            lane_q     <= ALU_in[1:0];
            valid_out  <= 1'b0;
            rd_we      <= 1'b0;
            redirect   <= 1'b0;
            misalign   <= 1'b0;
          end else begin
            // Non-memory ops and misaligned accesses retire directly.
            valid_out   <= valid_in;
            IR_out      <= IR_in;
            PC_out      <= PC_in;
            misalign    <= valid_in & is_mem;
            WB_out      <= is_mem ? 32'd0 : ((is_jal | is_jalr) ? link : ALU_in);
            rd_we       <= valid_in & ~is_mem & ~is_branch & (IR_in[11:7] != 5'd0);
            redirect    <= valid_in & ((is_branch & COMP_in) | is_jal | is_jalr);
            redirect_pc <= is_jalr ? (ALU_in & ~32'd1) : ALU_in;
          end
        end
        S_WAIT: begin
          if (dmem_ack) begin
            state     <= S_IDLE;
            dmem_req  <= 1'b0;
            valid_out <= 1'b1;
            IR_out    <= ir_q;
            PC_out    <= pc_q;
            WB_out    <= (ir_q[6:0] == OP_LOAD) ? load_data : 32'd0;
            rd_we     <= (ir_q[6:0] == OP_LOAD) & (ir_q[11:7] != 5'd0);
          end else begin
            valid_out <= 1'b0;
          end
          redirect <= 1'b0;
          misalign <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
